// File: rtl/mult_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : mult_seq_ctrl
// Purpose : Operand sequencer and product collector for an N-cycle bit-serial
//           multiplier. Optional overlap of product drain and operand accept
//           is enabled by defining MULT_SEQ_OVERLAP_EN.
// Revision: 1.0  initial release
// ============================================================================
module mult_seq_ctrl #(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  output logic           mult_rst,
  output logic [N-1:0]   mult_g,
  output logic           mult_e,
  input  logic [2*N-1:0] mult_o,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] out_prod
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     a_q, a_d;
  logic [N-1:0]     b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2*N-1:0]   prod_q, prod_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    prod_d    = prod_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    mult_e    = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          state_d = CLEAR;
        end
      end
      CLEAR: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        mult_e = b_q[0];
        b_d    = b_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        // Last serial bit is on mult_e this cycle, so mult_o is already final.
        if (cnt_q == CW'(N - 1)) begin
          prod_d  = mult_o;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
`ifdef MULT_SEQ_OVERLAP_EN
        in_ready = out_ready;
        if (out_ready && in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          state_d = CLEAR;
        end else if (out_ready) begin
          state_d = IDLE;
        end
`else
        if (out_ready) begin
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  assign mult_rst = rst | (state_q == CLEAR);
  assign mult_g   = a_q;
  assign out_prod = prod_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_seq_ctrl.sv
`default_nettype none
// Self-checking bench for mult_seq_ctrl with a behavioural bit-serial multiplier.
module tb_mult_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a, in_b;
  logic        mult_rst;
  logic [31:0] mult_g;
  logic        mult_e;
  logic [63:0] mult_o;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_prod;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  mult_seq_ctrl #(.N(32)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mult_rst(mult_rst), .mult_g(mult_g),
    .mult_e(mult_e), .mult_o(mult_o), .out_valid(out_valid),
    .out_ready(out_ready), .out_prod(out_prod)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Serial multiplier model: step k adds g * 2^k when e is set; output includes current step.
  logic [63:0] m_acc;
  int          m_k;
  assign mult_o = m_acc + ((mult_e && m_k < 32) ? ({32'b0, mult_g} << m_k) : 64'd0);
  always @(posedge clk) begin
    if (mult_rst) begin
      m_acc <= 64'd0;
      m_k   <= 0;
    end else begin
      m_acc <= mult_o;
      if (m_k < 64) m_k <= m_k + 1;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_accept(input logic [31:0] a, input logic [31:0] b,
                           output int acc_cyc, output bit ok);
    in_valid = 1'b1; in_a = a; in_b = b; ok = 1'b0; acc_cyc = 0;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) begin
        tick;
        ok = 1'b1;
        break;
      end
      tick;
    end
    acc_cyc  = cyc;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int vcyc, output bit ok);
    ok = 1'b0; vcyc = 0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) begin
        vcyc = cyc;
        ok   = 1'b1;
        break;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    tick; tick; tick;
    n_cmp++; if (mult_rst !== 1'b1) begin n_fail++; $display("FAIL reset_mult_rst got=%b exp=1", mult_rst); end
    rst = 1'b0;
    tick;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (mult_e !== 1'b0) begin n_fail++; $display("FAIL reset_mult_e got=%b exp=0", mult_e); end
    n_cmp++; if (mult_g !== 32'd0) begin n_fail++; $display("FAIL reset_mult_g got=%h exp=0", mult_g); end
    n_cmp++; if (out_prod !== 64'd0) begin n_fail++; $display("FAIL reset_out_prod got=%h exp=0", out_prod); end
    n_cmp++; if (mult_rst !== 1'b0) begin n_fail++; $display("FAIL reset_release_mult_rst got=%b exp=0", mult_rst); end
  endtask

  task automatic test_latency;
    int c0, v; bit ok, okv;
    out_ready = 1'b1;
    do_accept(32'd3, 32'd5, c0, ok);
    n_cmp++; if (!(mult_rst === 1'b1 && in_ready === 1'b0)) begin n_fail++; $display("FAIL clear_cycle got mult_rst=%b in_ready=%b exp 1/0", mult_rst, in_ready); end
    tick;
    n_cmp++; if (!(mult_rst === 1'b0 && mult_g === 32'd3 && in_ready === 1'b0)) begin n_fail++; $display("FAIL run_cycle got mult_rst=%b g=%h in_ready=%b exp 0/3/0", mult_rst, mult_g, in_ready); end
    wait_out(v, okv);
    n_cmp++; if (!ok || !okv || (v - c0) !== 33) begin n_fail++; $display("FAIL latency got=%0d exp=33", v - c0); end
    n_cmp++; if (out_prod !== 64'h000000000000000F) begin n_fail++; $display("FAIL prod_3x5 got=%h exp=f", out_prod); end
    tick;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_3x5 got out_valid=%b exp=0", out_valid); end
  endtask

  task automatic test_max;
    int c0, v; bit ok, okv;
    out_ready = 1'b1;
    do_accept(32'hFFFFFFFF, 32'hFFFFFFFF, c0, ok);
    wait_out(v, okv);
    n_cmp++; if (!ok || !okv || out_prod !== 64'hFFFFFFFE00000001) begin n_fail++; $display("FAIL prod_max got=%h exp=fffffffe00000001", out_prod); end
    tick;
  endtask

  task automatic test_backpressure;
    int c0, v; bit ok, okv, stable;
    out_ready = 1'b0;
    do_accept(32'h12345678, 32'd0, c0, ok);
    wait_out(v, okv);
    n_cmp++; if (!ok || !okv || out_prod !== 64'd0) begin n_fail++; $display("FAIL prod_zero got=%h exp=0", out_prod); end
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || out_prod !== 64'd0 || in_ready !== 1'b0) stable = 1'b0;
      tick;
    end
    n_cmp++; if (stable !== 1'b1) begin n_fail++; $display("FAIL backpressure_hold got=%b exp=1", stable); end
    out_ready = 1'b1;
    tick;
    n_cmp++; if (!(out_valid === 1'b0 && in_ready === 1'b1 && out_prod === 64'd0)) begin n_fail++; $display("FAIL backpressure_release got valid=%b ready=%b", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid;
    int c0, v; bit ok, okv, seen;
    out_ready = 1'b1;
    do_accept(32'hDEADBEEF, 32'hCAFEF00D, c0, ok);
    for (int i = 0; i < 11; i++) tick;
    rst = 1'b1;
    #1;
    n_cmp++; if (mult_rst !== 1'b1) begin n_fail++; $display("FAIL midrst_mult_rst got=%b exp=1", mult_rst); end
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (!(in_ready === 1'b1 && out_valid === 1'b0 && mult_g === 32'd0 && out_prod === 64'd0)) begin n_fail++; $display("FAIL midrst_idle got ready=%b valid=%b g=%h prod=%h", in_ready, out_valid, mult_g, out_prod); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid) seen = 1'b1;
      tick;
    end
    n_cmp++; if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_no_output got=%b exp=0", seen); end
    do_accept(32'd7, 32'd9, c0, ok);
    wait_out(v, okv);
    n_cmp++; if (!ok || !okv || out_prod !== 64'd63) begin n_fail++; $display("FAIL prod_7x9 got=%h exp=3f", out_prod); end
    tick;
  endtask

  task automatic test_ignore;
    int c0, v; bit ok, okv, rdy_low;
    out_ready = 1'b1;
    do_accept(32'hA5A50003, 32'h00000011, c0, ok);
    tick; tick; tick;
    rdy_low = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_a = $urandom; in_b = $urandom;
      if (in_ready !== 1'b0) rdy_low = 1'b0;
      tick;
    end
    in_valid = 1'b0;
    n_cmp++; if (rdy_low !== 1'b1) begin n_fail++; $display("FAIL ignore_in_ready got=%b exp=1", rdy_low); end
    wait_out(v, okv);
    n_cmp++; if (!ok || !okv || out_prod !== 64'hA5A50003 * 64'h11) begin n_fail++; $display("FAIL ignore_prod got=%h exp=%h", out_prod, 64'hA5A50003 * 64'h11); end
    tick;
  endtask

  task automatic test_back_to_back;
    int c0, nv, exp_gap; bit ok, take;
    int vt[2]; logic [63:0] vp[2];
`ifdef MULT_SEQ_OVERLAP_EN
    exp_gap = 34;
`else
    exp_gap = 35;
`endif
    out_ready = 1'b1; nv = 0;
    vt[0] = 0; vt[1] = 0; vp[0] = '0; vp[1] = '0;
    do_accept(32'd2, 32'd3, c0, ok);
    in_valid = 1'b1; in_a = 32'd4; in_b = 32'd5;
    for (int i = 0; i < 150 && nv < 2; i++) begin
      if (out_valid) begin vt[nv] = cyc; vp[nv] = out_prod; nv++; end
      take = in_ready && in_valid;
      tick;
      if (take) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    n_cmp++; if (!ok || nv !== 2) begin n_fail++; $display("FAIL b2b_count got=%0d exp=2", nv); end
    n_cmp++; if (vp[0] !== 64'd6 || vp[1] !== 64'd20) begin n_fail++; $display("FAIL b2b_prods got=%0d,%0d exp=6,20", vp[0], vp[1]); end
    n_cmp++; if ((vt[1] - vt[0]) !== exp_gap) begin n_fail++; $display("FAIL b2b_gap got=%0d exp=%0d", vt[1] - vt[0], exp_gap); end
    tick;
  endtask

  task automatic test_random;
    int c0, v; bit ok, okv;
    logic [31:0] a, b; logic [63:0] exp_p;
    for (int t = 0; t < 6; t++) begin
      a = $urandom; b = $urandom;
      if (t == 0) b = 32'h80000000;
      exp_p = {32'b0, a} * {32'b0, b};
      out_ready = 1'b0;
      do_accept(a, b, c0, ok);
      wait_out(v, okv);
      n_cmp++; if (!ok || !okv || (v - c0) !== 33 || out_prod !== exp_p) begin n_fail++; $display("FAIL rand_prod[%0d] got=%h lat=%0d exp=%h lat=33", t, out_prod, v - c0, exp_p); end
      for (int d = 0; d < int'($urandom_range(0, 4)); d++) tick;
      out_ready = 1'b1;
      tick;
    end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_max;
    test_backpressure;
    test_reset_mid;
    test_ignore;
    test_back_to_back;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire
